// File: rtl/unidade_controle_mc.sv
// Multicycle MIPS control FSM with configurable memory wait states, a separate decode
// state, branch/jump handling and EPC-based exceptions.
module unidade_controle_mc #(
    parameter int MEM_WAIT = 2,
    parameter int CW_W     = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [5:0]      flags,
    input  logic [5:0]      OPCODE,
    input  logic [5:0]      funct,
    output logic [CW_W-1:0] can_write,
    output logic [1:0]      PC_source,
    output logic [2:0]      Adress_source,
    output logic            M_ULAA,
    output logic [1:0]      M_ULAB,
    output logic [1:0]      M_REG_adress,
    output logic [2:0]      M_REG_data,
    output logic [2:0]      alu_op,
    output logic            exc_cause,
    output logic            reset_out
);

    localparam int CW_PC = 0, CW_MEM = 1, CW_IR = 2, CW_RF = 3, CW_AB = 4, CW_ALUO = 5, CW_EPC = 6;
    localparam logic [2:0] ALU_ADD = 3'b001, ALU_SUB = 3'b010, ALU_AND = 3'b011, ALU_CMP = 3'b111;
    localparam logic [2:0] FETCH_LAST = 3'(MEM_WAIT);

    typedef enum logic [3:0] {
        S_RESET, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_CHECK, S_WB,
        S_BRANCH, S_JUMP, S_JAL, S_JR, S_UNDEF, S_EXC1, S_EXC2
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       cause_q, cause_d;
    logic [6:0] cw;
    logic       ovf_inst, taken;
    logic       unused_flags;

    assign unused_flags = ^{flags[5], flags[1]};

    // ADDIU and the R-type AND never trap on overflow
    assign ovf_inst = ((OPCODE == 6'h00) && (funct == 6'h20 || funct == 6'h22)) ||
                      (OPCODE == 6'h08);

    always_comb begin
        taken = 1'b0;
        case (OPCODE)
            6'h04:   taken = flags[2];
            6'h05:   taken = !flags[2];
            6'h06:   taken = flags[3] | flags[2];
            6'h07:   taken = flags[4];
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        case (state_q)
            S_RESET: begin
                state_d = S_FETCH;
                cnt_d   = '0;
            end
            S_FETCH: begin
                if (cnt_q == FETCH_LAST) begin
                    state_d = S_DECODE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_DECODE: begin
                case (OPCODE)
                    6'h00: begin
                        if (funct == 6'h08) state_d = S_JR;
                        else if (funct == 6'h20 || funct == 6'h22 || funct == 6'h24) state_d = S_EXEC_R;
                        else begin
                            state_d = S_UNDEF;
                            cause_d = 1'b0;
                        end
                    end
                    6'h08, 6'h09:               state_d = S_EXEC_I;
                    6'h04, 6'h05, 6'h06, 6'h07: state_d = S_BRANCH;
                    6'h02:                      state_d = S_JUMP;
                    6'h03:                      state_d = S_JAL;
                    6'h3F:                      state_d = S_RESET;
                    default: begin
                        state_d = S_UNDEF;
                        cause_d = 1'b0;
                    end
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_d = S_CHECK;
            S_CHECK: begin
                if (flags[0] && ovf_inst) begin
                    state_d = S_EXC1;
                    cause_d = 1'b1;
                end else begin
                    state_d = S_WB;
                end
            end
            S_JAL:   state_d = S_JUMP;
            // Undefined opcodes idle one cycle so both trap paths enter EXC alike
            S_UNDEF: state_d = S_EXC1;
            S_EXC1:  state_d = S_EXC2;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
            cause_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        cw            = '0;
        PC_source     = 2'd0;
        Adress_source = 3'd0;
        M_ULAA        = 1'b0;
        M_ULAB        = 2'd0;
        M_REG_adress  = 2'd0;
        M_REG_data    = 3'd0;
        alu_op        = 3'd0;
        exc_cause     = 1'b0;
        reset_out     = 1'b0;
        case (state_q)
            S_RESET: reset_out = 1'b1;
            S_FETCH: begin
                M_ULAB = 2'd1;
                alu_op = ALU_ADD;
                if (cnt_q == FETCH_LAST) begin
                    cw[CW_PC] = 1'b1;
                    cw[CW_IR] = 1'b1;
                end
            end
            S_DECODE: begin
                cw[CW_AB]   = 1'b1;
                cw[CW_ALUO] = 1'b1;
                M_ULAB      = 2'd3;
                alu_op      = ALU_ADD;
            end
            S_EXEC_R: begin
                cw[CW_ALUO] = 1'b1;
                M_ULAA      = 1'b1;
                case (funct)
                    6'h22:   alu_op = ALU_SUB;
                    6'h24:   alu_op = ALU_AND;
                    default: alu_op = ALU_ADD;
                endcase
            end
            S_EXEC_I: begin
                cw[CW_ALUO] = 1'b1;
                M_ULAA      = 1'b1;
                M_ULAB      = 2'd2;
                alu_op      = ALU_ADD;
            end
            S_WB: begin
                cw[CW_RF]    = 1'b1;
                M_REG_adress = (OPCODE == 6'h00) ? 2'd1 : 2'd0;
            end
            S_BRANCH: begin
                M_ULAA    = 1'b1;
                alu_op    = ALU_CMP;
                PC_source = 2'd1;
                cw[CW_PC] = taken;
            end
            S_JUMP: begin
                PC_source = 2'd2;
                cw[CW_PC] = 1'b1;
            end
            S_JAL: begin
                cw[CW_RF]    = 1'b1;
                M_REG_adress = 2'd2;
                M_REG_data   = 3'd1;
            end
            S_JR: begin
                M_ULAA    = 1'b1;
                alu_op    = ALU_ADD;
                cw[CW_PC] = 1'b1;
            end
            S_EXC1: begin
                M_ULAB     = 2'd1;
                alu_op     = ALU_SUB;
                cw[CW_EPC] = 1'b1;
            end
            S_EXC2: begin
                PC_source = 2'd3;
                exc_cause = cause_q;
                cw[CW_PC] = 1'b1;
            end
            default: ;
        endcase
        can_write       = '0;
        can_write[6:0]  = cw;
        cw[CW_MEM]      = cw[CW_MEM];
    end

endmodule

// File: tb/tb_unidade_controle_mc.sv
// Randomised bench for unidade_controle_mc: each instruction is expanded by a small
// phase-level model into the expected per-cycle control vector sequence.
module tb_unidade_controle_mc;

    localparam int MW   = 2;
    localparam int CW_W = 7;

    logic            clk = 1'b0;
    logic            reset;
    logic [5:0]      flags, OPCODE, funct;
    logic [CW_W-1:0] can_write;
    logic [1:0]      PC_source, M_ULAB, M_REG_adress;
    logic [2:0]      Adress_source, M_REG_data, alu_op;
    logic            M_ULAA, exc_cause, reset_out;

    unidade_controle_mc #(.MEM_WAIT(MW), .CW_W(CW_W)) dut (
        .clk(clk), .reset(reset), .flags(flags), .OPCODE(OPCODE), .funct(funct),
        .can_write(can_write), .PC_source(PC_source), .Adress_source(Adress_source),
        .M_ULAA(M_ULAA), .M_ULAB(M_ULAB), .M_REG_adress(M_REG_adress),
        .M_REG_data(M_REG_data), .alu_op(alu_op), .exc_cause(exc_cause), .reset_out(reset_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       cause;
        logic [6:0] cw;
        logic [1:0] pcs;
        logic [2:0] adr;
        logic       ulaa;
        logic [1:0] ulab;
        logic [1:0] rega;
        logic [2:0] regd;
        logic [2:0] alu;
    } vec_t;

    localparam logic [6:0] W_PC = 7'h01, W_IR = 7'h04, W_RF = 7'h08, W_AB = 7'h10,
                           W_ALUO = 7'h20, W_EPC = 7'h40;
    localparam logic [2:0] ADD = 3'b001, SUB = 3'b010, AND_ = 3'b011, CMP = 3'b111;

    vec_t obs;
    always_comb obs = {reset_out, exc_cause, can_write[6:0], PC_source, Adress_source,
                       M_ULAA, M_ULAB, M_REG_adress, M_REG_data, alu_op};

    int   n_cmp = 0, n_err = 0;
    vec_t q[$];

    task automatic chk(input string tag, input vec_t e);
        n_cmp++;
        assert (obs === e)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    task automatic push_exc(input logic c);
        vec_t v;
        v = '0; v.ulab = 2'd1; v.alu = SUB; v.cw = W_EPC; q.push_back(v);
        v = '0; v.pcs = 2'd3; v.cause = c; v.cw = W_PC; q.push_back(v);
    endtask

    // Expected cycle-by-cycle trace for one instruction, from the phase descriptions
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic [5:0] fl);
        vec_t v;
        bit   is_r, is_i, taken;
        for (int i = 0; i <= MW; i++) begin
            v = '0; v.ulab = 2'd1; v.alu = ADD;
            if (i == MW) v.cw = W_PC | W_IR;
            q.push_back(v);
        end
        v = '0; v.cw = W_AB | W_ALUO; v.ulab = 2'd3; v.alu = ADD; q.push_back(v);
        is_r = (op == 6'h00) && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24);
        is_i = (op == 6'h08) || (op == 6'h09);
        if (is_r || is_i) begin
            v = '0; v.cw = W_ALUO; v.ulaa = 1'b1;
            v.ulab = is_r ? 2'd0 : 2'd2;
            v.alu = !is_r ? ADD : (fn == 6'h22) ? SUB : (fn == 6'h24) ? AND_ : ADD;
            q.push_back(v);
            q.push_back('0);
            if (fl[0] && ((is_r && fn != 6'h24) || op == 6'h08)) push_exc(1'b1);
            else begin
                v = '0; v.cw = W_RF; v.rega = is_r ? 2'd1 : 2'd0; q.push_back(v);
            end
        end else if (op >= 6'h04 && op <= 6'h07) begin
            case (op)
                6'h04:   taken = fl[2];
                6'h05:   taken = !fl[2];
                6'h06:   taken = fl[3] || fl[2];
                default: taken = fl[4];
            endcase
            v = '0; v.ulaa = 1'b1; v.alu = CMP; v.pcs = 2'd1; v.cw = taken ? W_PC : 7'h00;
            q.push_back(v);
        end else if (op == 6'h02 || op == 6'h03) begin
            if (op == 6'h03) begin
                v = '0; v.cw = W_RF; v.rega = 2'd2; v.regd = 3'd1; q.push_back(v);
            end
            v = '0; v.pcs = 2'd2; v.cw = W_PC; q.push_back(v);
        end else if (op == 6'h00 && fn == 6'h08) begin
            v = '0; v.ulaa = 1'b1; v.alu = ADD; v.cw = W_PC; q.push_back(v);
        end else if (op == 6'h3F) begin
            v = '0; v.rst = 1'b1; q.push_back(v);
        end else begin
            q.push_back('0);
            push_exc(1'b0);
        end
    endtask

    task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input logic [5:0] fl);
        vec_t e;
        OPCODE = op; funct = fn; flags = fl;
        build(op, fn, fl);
        while (q.size() > 0) begin
            @(negedge clk);
            e = q.pop_front();
            chk(tag, e);
        end
    endtask

    task automatic reset_release();
        vec_t v;
        v = '0; v.rst = 1'b1;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk); chk("reset_cycle", v);
    endtask

    initial begin
        vec_t rv, e;
        logic [5:0] op, fn;
        int sel;
        rv = '0; rv.rst = 1'b1;
        reset = 1'b0; OPCODE = '0; funct = '0; flags = '0;
        repeat (2) @(negedge clk);
        chk("reset_hold", rv);
        reset_release();

        run_instr("add",        6'h00, 6'h20, 6'h00);
        run_instr("beq_taken",  6'h04, 6'h00, 6'h04);
        run_instr("beq_nottkn", 6'h04, 6'h00, 6'h00);
        run_instr("bgt_taken",  6'h07, 6'h00, 6'h10);
        run_instr("addi_ovf",   6'h08, 6'h00, 6'h01);
        run_instr("addiu_ovf",  6'h09, 6'h00, 6'h01);
        run_instr("rst_op",     6'h3F, 6'h00, 6'h00);
        run_instr("undef_op",   6'h11, 6'h00, 6'h00);
        run_instr("jal",        6'h03, 6'h00, 6'h00);
        run_instr("jr",         6'h00, 6'h08, 6'h00);
        run_instr("sub_ovf",    6'h00, 6'h22, 6'h01);

        // Abort an add in its write-back cycle
        OPCODE = 6'h00; funct = 6'h20; flags = 6'h00;
        build(6'h00, 6'h20, 6'h00);
        while (q.size() > 0) begin
            @(negedge clk);
            e = q.pop_front();
            chk("abort_pre", e);
        end
        #1 reset = 1'b0;
        #1 chk("abort_async", rv);
        @(negedge clk); chk("abort_hold", rv);
        reset_release();

        for (int n = 0; n < 80; n++) begin
            sel = $urandom_range(0, 15);
            fn  = 6'($urandom);
            case (sel)
                0: begin op = 6'h00; fn = 6'h20; end
                1: begin op = 6'h00; fn = 6'h22; end
                2: begin op = 6'h00; fn = 6'h24; end
                3: begin op = 6'h00; fn = 6'h08; end
                4: op = 6'h08;
                5: op = 6'h09;
                6: op = 6'h04;
                7: op = 6'h05;
                8: op = 6'h06;
                9: op = 6'h07;
                10: op = 6'h02;
                11: op = 6'h03;
                12: op = 6'h3F;
                13: op = 6'h00;
                default: op = 6'($urandom);
            endcase
            run_instr("random", op, fn, 6'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
